// File: rtl/mdu_pkg.sv
// Shared MDU definitions: MDUControl op-codes, default latencies and op helpers.
// Also imported by the pipeline controller and the hazard unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  function automatic logic is_muldiv_op(logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_mult_op(logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage operand/control bundle between the pipeline (master) and the MDU (slave).
interface mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  MDUControl;
  logic        Start;
  logic        Req;
  logic        Busy;
  logic [31:0] MDUResult;

  modport master (
    output SrcA, SrcB, MDUControl, Start, Req,
    input  Busy, MDUResult
  );

  modport slave (
    input  SrcA, SrcB, MDUControl, Start, Req,
    output Busy, MDUResult
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing {HI,LO} and a divide-by-zero flag.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  op,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] mul_a_s;
  logic signed [63:0] mul_b_s;
  logic [63:0]        mul_s;
  logic [63:0]        mul_u;
  logic               is_signed_div;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        quot;
  logic [31:0]        rem;

  assign mul_a_s = {{32{src_a[31]}}, src_a};
  assign mul_b_s = {{32{src_b[31]}}, src_b};
  assign mul_s   = mul_a_s * mul_b_s;
  assign mul_u   = {32'h0, src_a} * {32'h0, src_b};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign is_signed_div = (op == MDU_DIV);
  assign a_neg = is_signed_div && src_a[31];
  assign b_neg = is_signed_div && src_b[31];
  assign a_mag = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag = b_neg ? (~src_b + 32'd1) : src_b;

  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  assign quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    result      = '0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT:  result = mul_s;
      MDU_MULTU: result = mul_u;
      MDU_DIV, MDU_DIVU: begin
        result      = {rem, quot};
        div_by_zero = (src_b == '0);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are computed at accept
// and held in Tmp registers until the busy countdown commits them.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d;
  logic [31:0]      tmp_lo_q, tmp_lo_d;
  logic             dbz_q, dbz_d;

  logic [63:0]      calc_result;
  logic             calc_dbz;
  logic             busy;
  logic             accept;
  logic             write_ok;

  mdu_calc u_calc (
    .src_a       (bus.SrcA),
    .src_b       (bus.SrcB),
    .op          (bus.MDUControl),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  assign busy     = (cnt_q != '0);
  assign write_ok = !bus.Req && !busy;
  assign accept   = write_ok && bus.Start && is_muldiv_op(bus.MDUControl);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  // Req never cancels an op already counting down; it only gates new writes.
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    dbz_d    = dbz_q;

    if (accept) begin
      tmp_hi_d = calc_result[63:32];
      tmp_lo_d = calc_result[31:0];
      dbz_d    = calc_dbz;
      cnt_d    = is_mult_op(bus.MDUControl) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1) && !dbz_q) begin
        hi_d = tmp_hi_q;
        lo_d = tmp_lo_q;
      end
    end else if (write_ok) begin
      if (bus.MDUControl == MDU_MTHI) hi_d = bus.SrcA;
      if (bus.MDUControl == MDU_MTLO) lo_d = bus.SrcA;
    end
  end

  always_comb begin
    bus.Busy      = busy;
    bus.MDUResult = '0;
    case (bus.MDUControl)
      MDU_MFHI: bus.MDUResult = hi_q;
      MDU_MFLO: bus.MDUResult = lo_q;
      default:  bus.MDUResult = '0;
    endcase
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage, alongside the ALU; takes the same forwarded SrcA/SrcB operands.
- Implements mult/multu/div/divu with multi-cycle latency, and owns the HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Provides a Busy signal to the hazard unit, which stalls D-stage MDU instructions.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
SrcA  input  32  rs operand, forwarded
SrcB  input  32  rt operand, forwarded
MDUControl  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others treated as none
Start  input  1  E-stage instruction is mult/multu/div/divu
Req  input  1  exception/interrupt flush; suppresses this cycle's Start and mthi/mtlo
Busy  output  1  operation in flight
MDUResult  output  32  mfhi: HI; mflo: LO; otherwise 0 (combinational)

Behaviour:
- Reset (reset_n low, asynchronous): HI, LO, counter, and the product/quotient holding registers all clear to 0; Busy = 0.
- Accept condition: at a rising edge with Start=1, Req=0, Busy=0 and MDUControl in 1..4.
  - The result is computed from SrcA/SrcB at that edge and latched into internal TmpHI/TmpLO.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
- Busy = (counter != 0). It is high for exactly N cycles after the accept edge.
- Each edge with counter != 0 decrements the counter. On the edge where it goes 1->0, HI<=TmpHI and LO<=TmpLO; Busy drops in the same cycle.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: unsigned 32x32 -> 64; same HI/LO split.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - divu: unsigned quotient/remainder.
  - Divide by zero (SrcB == 0): the operation runs the full DIV_CYCLES with Busy high, but HI/LO keep their old values at commit.
- mthi/mtlo: HI or LO <= SrcA at the edge, when Req=0 and Busy=0; single cycle; no Busy.
- Writes suppressed while Busy: Start and mthi/mtlo are ignored. The hazard unit guarantees they do not occur; the bench checks that the block ignores them anyway.
- mfhi/mflo reads:
  - Read the committed HI/LO combinationally.
  - A read while Busy returns the old value; the stall makes this unobservable.
  - No bypass from a same-cycle mthi/mtlo.
- Req=1 flush semantics:
  - Blocks the accept and the mthi/mtlo writes that cycle.
  - An already-accepted operation is not cancelled; it completes and commits, per MIPS precise-exception semantics.
- A reset asserted mid-operation aborts it immediately; no commit occurs.

Decomposition:
- Shared package (mdu_pkg), holding:
  - MDUControl op-code constants: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO.
  - Default cycle-count constants.
  - The same package is used by the controller and the hazard unit.
- Sub-module mdu_calc: combinational; takes SrcA, SrcB and op; produces the 64-bit {HI,LO} result plus a div-by-zero flag.
- Top level (mdu): counter, HI/LO/Tmp registers, Busy and read mux.

Test Plan:
- mult, SrcA=0xFFFFFFFE (-2), SrcB=3, Start 1 cycle -> Busy high exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA after Busy falls; mfhi/mflo return these.
- multu, 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div, -7 / 2 -> Busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- mthi 0x12345678 then divu 5 / 0 -> HI stays 0x12345678 after 10 busy cycles; LO unchanged.
- Req=1 with Start (mult 3x4) -> Busy stays 0, HI/LO unchanged. Req=1 raised 2 cycles into an accepted mult -> still commits at cycle 5.
- reset_n pulsed low at cycle 3 of a div -> Busy=0, HI=LO=0 immediately, asynchronously. A second Start while Busy -> ignored; the first result is committed unchanged.
